// File: rtl/nav_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : nav_pkg
//  Description : Shared direction, colour and state codes for the navigation
//                controller, plus the obstacle-priority helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package nav_pkg;

    typedef enum logic [2:0] {
        DIR_FWD   = 3'b000,
        DIR_BACK  = 3'b001,
        DIR_STOP  = 3'b010,
        DIR_LEFT  = 3'b100,
        DIR_RIGHT = 3'b101
    } dir_e;

    typedef enum logic [2:0] {
        COL_RED     = 3'b000,
        COL_BLUE    = 3'b001,
        COL_GREEN   = 3'b010,
        COL_YELLOW  = 3'b011,
        COL_UNKNOWN = 3'b100
    } color_e;

    typedef enum logic [3:0] {
        ST_SEARCH_FWD  = 4'd0,
        ST_SEARCH_TURN = 4'd1,
        ST_AVOID_TURN  = 4'd2,
        ST_AVOID_FWD   = 4'd3,
        ST_PICKUP      = 4'd4,
        ST_CARRY       = 4'd5,
        ST_DROP        = 4'd6,
        ST_DONE        = 4'd7
    } state_e;

    localparam logic [1:0] c_speed_off  = 2'd0;
    localparam logic [1:0] c_speed_full = 2'd3;

    typedef struct packed {
        logic hit;
        dir_e dir;
    } avoid_t;

    // Front is the only trigger; a blocked left side steers right, otherwise left.
    function automatic avoid_t avoid_decide(input logic front, input logic left);
        avoid_t r;
        r.hit = front;
        r.dir = (front && left) ? DIR_RIGHT : DIR_LEFT;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nav_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : nav_controller_if
//  Description : Sensor inputs and actuator outputs of the navigation block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nav_controller_if #(
    parameter int MAX_WASHERS = 4
) ();
    import nav_pkg::*;

    localparam int c_cnt_w = $clog2(MAX_WASHERS + 1);

    logic               ir_front;
    logic               ir_left;
    logic               ir_right;
    logic               metal_det;
    logic               color_valid;
    logic [2:0]         color_code;
    logic               led_match;
    dir_e               direction;
    logic [1:0]         speed;
    logic               magnet_on;
    logic [2:0]         held_color;
    logic [c_cnt_w-1:0] washer_count;
    logic [3:0]         state_dbg;

    modport master (
        input  ir_front, ir_left, ir_right, metal_det, color_valid, color_code, led_match,
        output direction, speed, magnet_on, held_color, washer_count, state_dbg
    );

    modport slave (
        output ir_front, ir_left, ir_right, metal_det, color_valid, color_code, led_match,
        input  direction, speed, magnet_on, held_color, washer_count, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/input_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : input_debounce
//  Description : Accepts a new input level only after DEB_CYC consecutive
//                samples disagree with the current filtered level.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_debounce #(
    parameter int DEB_CYC = 1000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_raw,
    output logic      o_filt
);
    localparam int              c_cw   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DEB_CYC - 1);

    logic [c_cw-1:0] r_cnt_q;
    logic [c_cw-1:0] w_cnt_d;
    logic            r_filt_q;
    logic            w_filt_d;

    // Any sample agreeing with the filtered level restarts the stability run.
    always_comb begin
        w_cnt_d  = '0;
        w_filt_d = r_filt_q;
        if (i_raw != r_filt_q) begin
            if (r_cnt_q == c_last) begin
                w_filt_d = i_raw;
            end else begin
                w_cnt_d = r_cnt_q + c_cw'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q  <= '0;
            r_filt_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_filt_q <= w_filt_d;
        end
    end

    assign o_filt = r_filt_q;
endmodule
`default_nettype wire

// File: rtl/nav_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : nav_controller
//  Description : Washer-collecting robot navigator: search pattern, obstacle
//                avoidance, magnetic pickup, colour-matched delivery.
//  Revision    : 1.0 - initial release
// ============================================================================
module nav_controller
    import nav_pkg::*;
#(
    parameter int TURN_CYC    = 40_000_000,
    parameter int FWD_CYC     = 20_000_000,
    parameter int LEG_CYC     = 400_000_000,
    parameter int SWEEP_CYC   = 200_000_000,
    parameter int DROP_CYC    = 50_000_000,
    parameter int DEB_CYC     = 1000,
    parameter int MAX_WASHERS = 4,
    parameter int CNT_W       = 32
) (
    input  wire logic        CLK100MHZ,
    input  wire logic        reset,
    nav_controller_if.master bus
);
    localparam int               c_cnt_w      = $clog2(MAX_WASHERS + 1);
    localparam logic [CNT_W-1:0] c_turn_last  = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] c_fwd_last   = CNT_W'(FWD_CYC - 1);
    localparam logic [CNT_W-1:0] c_leg_last   = CNT_W'(LEG_CYC - 1);
    localparam logic [CNT_W-1:0] c_sweep_last = CNT_W'(SWEEP_CYC - 1);
    localparam logic [CNT_W-1:0] c_drop_last  = CNT_W'(DROP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_max      = c_cnt_w'(MAX_WASHERS);

    logic [4:0] w_raw;
    logic [4:0] w_filt;

    assign w_raw = {bus.led_match, bus.metal_det, bus.ir_right, bus.ir_left, bus.ir_front};

    for (genvar gi = 0; gi < 5; gi++) begin : g_deb
        input_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk    (CLK100MHZ),
            .rst    (reset),
            .i_raw  (w_raw[gi]),
            .o_filt (w_filt[gi])
        );
    end

    logic w_front, w_left, w_metal, w_led;
    assign w_front = w_filt[0];
    assign w_left  = w_filt[1];
    assign w_metal = w_filt[3];
    assign w_led   = w_filt[4];

    state_e             r_state_q,      w_state_d;
    logic [CNT_W-1:0]   r_timer_q,      w_timer_d;
    dir_e               r_turn_q,       w_turn_d;
    logic               r_alt_right_q,  w_alt_right_d;
    logic               r_ret_carry_q,  w_ret_carry_d;
    logic               r_carry_turn_q, w_carry_turn_d;
    logic [2:0]         r_held_q,       w_held_d;
    logic [c_cnt_w-1:0] r_count_q,      w_count_d;
    dir_e               r_dir_q,        w_dir_d;
    logic [1:0]         r_speed_q,      w_speed_d;
    logic               r_magnet_q,     w_magnet_d;

    logic [CNT_W-1:0]   w_timer_sat;
    logic [c_cnt_w-1:0] w_count_inc;
    logic               w_restart;
    avoid_t             w_avoid;

    assign w_timer_sat = (r_timer_q == '1) ? r_timer_q : r_timer_q + CNT_W'(1);
    assign w_count_inc = r_count_q + c_cnt_w'(1);
    assign w_avoid     = avoid_decide(w_front, w_left);

    always_comb begin
        w_state_d      = r_state_q;
        w_turn_d       = r_turn_q;
        w_alt_right_d  = r_alt_right_q;
        w_ret_carry_d  = r_ret_carry_q;
        w_carry_turn_d = r_carry_turn_q;
        w_held_d       = r_held_q;
        w_count_d      = r_count_q;
        w_restart      = 1'b0;

        case (r_state_q)
            ST_SEARCH_FWD: begin
                if (w_metal) begin
                    w_state_d = ST_PICKUP;
                end else if (w_avoid.hit) begin
                    w_state_d     = ST_AVOID_TURN;
                    w_turn_d      = w_avoid.dir;
                    w_ret_carry_d = 1'b0;
                end else if (r_timer_q == c_leg_last) begin
                    w_state_d     = ST_SEARCH_TURN;
                    w_turn_d      = r_alt_right_q ? DIR_RIGHT : DIR_LEFT;
                    w_alt_right_d = ~r_alt_right_q;
                end
            end
            ST_SEARCH_TURN: begin
                if (w_metal) begin
                    w_state_d = ST_PICKUP;
                end else if (w_avoid.hit) begin
                    w_state_d     = ST_AVOID_TURN;
                    w_turn_d      = w_avoid.dir;
                    w_ret_carry_d = 1'b0;
                end else if (r_timer_q == c_sweep_last) begin
                    w_state_d = ST_SEARCH_FWD;
                end
            end
            ST_AVOID_TURN: begin
                if (r_timer_q == c_turn_last) begin
                    w_state_d = ST_AVOID_FWD;
                end
            end
            ST_AVOID_FWD: begin
                if (w_avoid.hit) begin
                    w_state_d = ST_AVOID_TURN;
                    w_turn_d  = w_avoid.dir;
                end else if (r_timer_q == c_fwd_last) begin
                    w_state_d      = r_ret_carry_q ? ST_CARRY : ST_SEARCH_FWD;
                    w_carry_turn_d = 1'b0;
                end
            end
            ST_PICKUP: begin
                if (bus.color_valid) begin
                    w_state_d      = ST_CARRY;
                    w_held_d       = bus.color_code;
                    w_carry_turn_d = 1'b0;
                end else if (r_timer_q == c_sweep_last) begin
                    w_state_d      = ST_CARRY;
                    w_held_d       = COL_UNKNOWN;
                    w_carry_turn_d = 1'b0;
                end
            end
            ST_CARRY: begin
                // Carrying reuses the search leg/sweep cadence as an internal phase.
                if (w_led) begin
                    w_state_d = ST_DROP;
                end else if (w_avoid.hit) begin
                    w_state_d     = ST_AVOID_TURN;
                    w_turn_d      = w_avoid.dir;
                    w_ret_carry_d = 1'b1;
                end else if (!r_carry_turn_q && r_timer_q == c_leg_last) begin
                    w_carry_turn_d = 1'b1;
                    w_turn_d       = r_alt_right_q ? DIR_RIGHT : DIR_LEFT;
                    w_alt_right_d  = ~r_alt_right_q;
                    w_restart      = 1'b1;
                end else if (r_carry_turn_q && r_timer_q == c_sweep_last) begin
                    w_carry_turn_d = 1'b0;
                    w_restart      = 1'b1;
                end
            end
            ST_DROP: begin
                if (r_timer_q == c_drop_last) begin
                    w_count_d = w_count_inc;
                    w_state_d = (w_count_inc == c_max) ? ST_DONE : ST_SEARCH_FWD;
                end
            end
            default: begin
                w_state_d = ST_DONE;
            end
        endcase

        w_timer_d = (w_state_d != r_state_q || w_restart) ? '0 : w_timer_sat;

        w_dir_d    = DIR_STOP;
        w_speed_d  = c_speed_full;
        w_magnet_d = 1'b0;
        case (w_state_d)
            ST_SEARCH_FWD:  w_dir_d = DIR_FWD;
            ST_SEARCH_TURN: w_dir_d = w_turn_d;
            ST_AVOID_TURN: begin
                w_dir_d    = w_turn_d;
                w_magnet_d = w_ret_carry_d;
            end
            ST_AVOID_FWD: begin
                w_dir_d    = DIR_FWD;
                w_magnet_d = w_ret_carry_d;
            end
            ST_PICKUP: begin
                w_speed_d  = c_speed_off;
                w_magnet_d = 1'b1;
            end
            ST_CARRY: begin
                w_dir_d    = w_carry_turn_d ? w_turn_d : DIR_FWD;
                w_magnet_d = 1'b1;
            end
            default: begin
                w_speed_d = c_speed_off;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state_q      <= ST_SEARCH_FWD;
            r_timer_q      <= '0;
            r_turn_q       <= DIR_LEFT;
            r_alt_right_q  <= 1'b0;
            r_ret_carry_q  <= 1'b0;
            r_carry_turn_q <= 1'b0;
            r_held_q       <= COL_UNKNOWN;
            r_count_q      <= '0;
            r_dir_q        <= DIR_STOP;
            r_speed_q      <= c_speed_off;
            r_magnet_q     <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_timer_q      <= w_timer_d;
            r_turn_q       <= w_turn_d;
            r_alt_right_q  <= w_alt_right_d;
            r_ret_carry_q  <= w_ret_carry_d;
            r_carry_turn_q <= w_carry_turn_d;
            r_held_q       <= w_held_d;
            r_count_q      <= w_count_d;
            r_dir_q        <= w_dir_d;
            r_speed_q      <= w_speed_d;
            r_magnet_q     <= w_magnet_d;
        end
    end

    assign bus.direction    = r_dir_q;
    assign bus.speed        = r_speed_q;
    assign bus.magnet_on    = r_magnet_q;
    assign bus.held_color   = r_held_q;
    assign bus.washer_count = r_count_q;
    assign bus.state_dbg    = r_state_q;
endmodule
`default_nettype wire

// File: tb/tb_nav_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_nav_controller
//  Description : Directed bench for nav_controller with a cycle model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nav_controller;
    import nav_pkg::*;

    localparam int TURN_CYC    = 10;
    localparam int FWD_CYC     = 8;
    localparam int LEG_CYC     = 20;
    localparam int SWEEP_CYC   = 12;
    localparam int DROP_CYC    = 9;
    localparam int DEB_CYC     = 8;
    localparam int MAX_WASHERS = 4;
    localparam int CNT_W       = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nav_controller_if #(.MAX_WASHERS(MAX_WASHERS)) bus ();

    nav_controller #(
        .TURN_CYC(TURN_CYC), .FWD_CYC(FWD_CYC), .LEG_CYC(LEG_CYC),
        .SWEEP_CYC(SWEEP_CYC), .DROP_CYC(DROP_CYC), .DEB_CYC(DEB_CYC),
        .MAX_WASHERS(MAX_WASHERS), .CNT_W(CNT_W)
    ) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (countdown per mode) ----------------
    state_e           m_mode = ST_SEARCH_FWD;
    int               m_left = 0;
    logic [2:0]       m_turn = 3'b100;
    bit               m_alt = 0, m_ret = 0, m_ct = 0, m_rst = 1;
    logic [2:0]       m_held = 3'b100;
    int               m_cnt = 0;
    bit [4:0]         m_filt = '0;
    bit [DEB_CYC-1:0] m_sh [5];
    bit               model_en = 0;

    function automatic void m_enter(input state_e s, input int dur);
        m_mode = s;
        m_left = dur;
    endfunction

    task automatic m_step();
        bit [4:0]   raw;
        bit         hit;
        logic [2:0] adir;
        if (reset) begin
            m_enter(ST_SEARCH_FWD, LEG_CYC);
            m_turn = 3'b100; m_alt = 0; m_ret = 0; m_ct = 0; m_rst = 1;
            m_held = 3'b100; m_cnt = 0; m_filt = '0;
            for (int i = 0; i < 5; i++) m_sh[i] = '0;
            return;
        end
        m_rst = 0;
        raw  = {bus.led_match, bus.metal_det, bus.ir_right, bus.ir_left, bus.ir_front};
        hit  = m_filt[0];
        adir = (m_filt[0] && m_filt[1]) ? 3'b101 : 3'b100;
        case (m_mode)
            ST_SEARCH_FWD, ST_SEARCH_TURN: begin
                if (m_filt[3]) m_enter(ST_PICKUP, SWEEP_CYC);
                else if (hit) begin m_turn = adir; m_ret = 0; m_enter(ST_AVOID_TURN, TURN_CYC); end
                else if (m_left == 1) begin
                    if (m_mode == ST_SEARCH_FWD) begin
                        m_turn = m_alt ? 3'b101 : 3'b100;
                        m_alt  = !m_alt;
                        m_enter(ST_SEARCH_TURN, SWEEP_CYC);
                    end else m_enter(ST_SEARCH_FWD, LEG_CYC);
                end else m_left--;
            end
            ST_AVOID_TURN: begin
                if (m_left == 1) m_enter(ST_AVOID_FWD, FWD_CYC); else m_left--;
            end
            ST_AVOID_FWD: begin
                if (hit) begin m_turn = adir; m_enter(ST_AVOID_TURN, TURN_CYC); end
                else if (m_left == 1) begin
                    m_ct = 0;
                    m_enter(m_ret ? ST_CARRY : ST_SEARCH_FWD, LEG_CYC);
                end else m_left--;
            end
            ST_PICKUP: begin
                if (bus.color_valid) begin m_held = bus.color_code; m_ct = 0; m_enter(ST_CARRY, LEG_CYC); end
                else if (m_left == 1) begin m_held = 3'b100; m_ct = 0; m_enter(ST_CARRY, LEG_CYC); end
                else m_left--;
            end
            ST_CARRY: begin
                if (m_filt[4]) m_enter(ST_DROP, DROP_CYC);
                else if (hit) begin m_turn = adir; m_ret = 1; m_enter(ST_AVOID_TURN, TURN_CYC); end
                else if (m_left == 1) begin
                    if (!m_ct) begin
                        m_ct = 1; m_turn = m_alt ? 3'b101 : 3'b100; m_alt = !m_alt; m_left = SWEEP_CYC;
                    end else begin
                        m_ct = 0; m_left = LEG_CYC;
                    end
                end else m_left--;
            end
            ST_DROP: begin
                if (m_left == 1) begin
                    m_cnt++;
                    if (m_cnt == MAX_WASHERS) m_mode = ST_DONE;
                    else m_enter(ST_SEARCH_FWD, LEG_CYC);
                end else m_left--;
            end
            default: ;
        endcase
        for (int i = 0; i < 5; i++) begin
            m_sh[i] = {m_sh[i][DEB_CYC-2:0], raw[i]};
            if (&m_sh[i]) m_filt[i] = 1;
            else if (m_sh[i] == '0) m_filt[i] = 0;
        end
    endtask

    function automatic logic [2:0] e_dir();
        if (m_rst) return 3'b010;
        case (m_mode)
            ST_SEARCH_FWD, ST_AVOID_FWD:   return 3'b000;
            ST_SEARCH_TURN, ST_AVOID_TURN: return m_turn;
            ST_CARRY:                      return m_ct ? m_turn : 3'b000;
            default:                       return 3'b010;
        endcase
    endfunction

    function automatic int e_speed();
        if (m_rst) return 0;
        if (m_mode == ST_PICKUP || m_mode == ST_DROP || m_mode == ST_DONE) return 0;
        return 3;
    endfunction

    function automatic int e_magnet();
        if (m_rst) return 0;
        if (m_mode == ST_PICKUP || m_mode == ST_CARRY) return 1;
        if (m_mode == ST_AVOID_TURN || m_mode == ST_AVOID_FWD) return int'(m_ret);
        return 0;
    endfunction

    always @(posedge clk) m_step();

    always @(negedge clk) begin
        if (model_en) begin
            chk("model_direction", bus.direction, e_dir());
            chk("model_speed", bus.speed, e_speed());
            chk("model_magnet", bus.magnet_on, e_magnet());
            chk("model_held", bus.held_color, m_held);
            chk("model_count", bus.washer_count, m_cnt);
            chk("model_state", bus.state_dbg, m_mode);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_state(input state_e st, input int bound, input string name);
        int n = 0;
        while (bus.state_dbg != st && n < bound) begin tick(); n++; end
        chk(name, bus.state_dbg, st);
    endtask

    task automatic run_len(input state_e st, output int n);
        n = 0;
        while (bus.state_dbg == st && n < 500) begin n++; tick(); end
    endtask

    task automatic strobe(input logic [2:0] code);
        bus.color_code  = code;
        bus.color_valid = 1'b1;
        tick();
        bus.color_valid = 1'b0;
    endtask

    task automatic pickup_strobe(input logic [2:0] code);
        bus.metal_det = 1'b1;
        wait_state(ST_PICKUP, 50, "pickup_wait");
        bus.metal_det = 1'b0;
        repeat (DEB_CYC + 1) tick();
        strobe(code);
        chk("pickup_held", bus.held_color, code);
        chk("pickup_carry", bus.state_dbg, ST_CARRY);
    endtask

    task automatic deliver(input int exp_cnt);
        int n;
        bus.led_match = 1'b1;
        wait_state(ST_DROP, 50, "drop_wait");
        chk("drop_magnet", bus.magnet_on, 0);
        chk("drop_speed", bus.speed, 0);
        bus.led_match = 1'b0;
        run_len(ST_DROP, n);
        chk("drop_len", n, DROP_CYC);
        chk("washer_count", bus.washer_count, exp_cnt);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.ir_front = 0; bus.ir_left = 0; bus.ir_right = 0; bus.metal_det = 0;
        bus.color_valid = 0; bus.color_code = 3'b000; bus.led_match = 0;
        repeat (3) tick();
        model_en = 1;
        chk("rst_dir", bus.direction, 3'b010);
        chk("rst_speed", bus.speed, 0);
        chk("rst_state", bus.state_dbg, ST_SEARCH_FWD);
        chk("rst_held", bus.held_color, 3'b100);
        chk("rst_count", bus.washer_count, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_dir", bus.direction, 3'b000);
        chk("post_rst_speed", bus.speed, 3);

        // search pattern: left first, then right
        run_len(ST_SEARCH_FWD, n);
        chk("sweep1_dir", bus.direction, 3'b100);
        run_len(ST_SEARCH_TURN, n);
        chk("sweep_len", n, SWEEP_CYC);
        run_len(ST_SEARCH_FWD, n);
        chk("leg_len", n, LEG_CYC);
        chk("sweep2_dir", bus.direction, 3'b101);
        run_len(ST_SEARCH_TURN, n);

        // front obstacle
        bus.ir_front = 1'b1;
        n = 0;
        do begin tick(); n++; end while (bus.direction != 3'b100 && n < 100);
        chk("front_latency", n, DEB_CYC + 1);
        bus.ir_front = 1'b0;
        chk("front_state", bus.state_dbg, ST_AVOID_TURN);
        run_len(ST_AVOID_TURN, n);
        chk("avoid_turn_len", n, TURN_CYC);
        chk("avoid_fwd_dir", bus.direction, 3'b000);
        run_len(ST_AVOID_FWD, n);
        chk("avoid_fwd_len", n, FWD_CYC);
        chk("avoid_return", bus.state_dbg, ST_SEARCH_FWD);

        // front + left steers right
        bus.ir_front = 1'b1; bus.ir_left = 1'b1;
        wait_state(ST_AVOID_TURN, 50, "fl_wait");
        chk("front_left_dir", bus.direction, 3'b101);
        bus.ir_front = 1'b0; bus.ir_left = 1'b0;
        wait_state(ST_SEARCH_FWD, 100, "fl_return");

        // left alone is not an obstacle
        bus.ir_left = 1'b1;
        repeat (DEB_CYC + 4) begin tick(); chk("left_only_state", bus.state_dbg, ST_SEARCH_FWD); end
        bus.ir_left = 1'b0;
        repeat (DEB_CYC + 1) tick();

        // metal beats front
        bus.metal_det = 1'b1; bus.ir_front = 1'b1;
        wait_state(ST_PICKUP, 50, "metal_wait");
        chk("pickup_magnet", bus.magnet_on, 1);
        chk("pickup_dir", bus.direction, 3'b010);
        chk("pickup_speed", bus.speed, 0);
        bus.metal_det = 1'b0; bus.ir_front = 1'b0;
        repeat (DEB_CYC + 1) tick();
        strobe(3'b010);
        chk("carry_state", bus.state_dbg, ST_CARRY);
        chk("held_green", bus.held_color, 3'b010);
        chk("carry_magnet", bus.magnet_on, 1);
        deliver(1);
        chk("after_drop1", bus.state_dbg, ST_SEARCH_FWD);

        // pickup timeout
        bus.metal_det = 1'b1;
        wait_state(ST_PICKUP, 50, "timeout_wait");
        bus.metal_det = 1'b0;
        run_len(ST_PICKUP, n);
        chk("pickup_timeout_len", n, SWEEP_CYC);
        chk("timeout_held", bus.held_color, 3'b100);
        chk("timeout_carry", bus.state_dbg, ST_CARRY);
        deliver(2);

        // avoidance while carrying keeps the washer
        pickup_strobe(3'b001);
        bus.ir_front = 1'b1; bus.ir_right = 1'b1;
        wait_state(ST_AVOID_TURN, 50, "carry_avoid_wait");
        chk("carry_avoid_dir", bus.direction, 3'b100);
        chk("carry_avoid_magnet", bus.magnet_on, 1);
        bus.ir_front = 1'b0; bus.ir_right = 1'b0;
        wait_state(ST_CARRY, 100, "carry_resume");
        deliver(3);

        pickup_strobe(3'b011);
        deliver(4);
        chk("done_state", bus.state_dbg, ST_DONE);
        chk("done_speed", bus.speed, 0);

        // DONE ignores everything
        bus.ir_front = 1; bus.metal_det = 1; bus.led_match = 1;
        bus.color_valid = 1; bus.color_code = 3'b000;
        repeat (30) begin tick(); chk("done_hold", bus.state_dbg, ST_DONE); end
        bus.ir_front = 0; bus.metal_det = 0; bus.led_match = 0; bus.color_valid = 0;
        chk("done_count", bus.washer_count, 4);
        chk("done_held", bus.held_color, 3'b011);

        // reset in the middle of an avoidance turn
        reset = 1'b1; tick(); reset = 1'b0; tick();
        bus.ir_front = 1'b1;
        wait_state(ST_AVOID_TURN, 50, "rst_avoid_wait");
        bus.ir_front = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_avoid_dir", bus.direction, 3'b010);
        chk("rst_avoid_speed", bus.speed, 0);
        chk("rst_avoid_state", bus.state_dbg, ST_SEARCH_FWD);
        chk("rst_avoid_count", bus.washer_count, 0);
        reset = 1'b0;
        tick();
        chk("rst_avoid_release", bus.direction, 3'b000);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nav_controller.md
NAV_CONTROLLER -- requirements
Module: nav_controller

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- TURN_CYC, 40_000_000: cycles per avoidance turn.
- FWD_CYC, 20_000_000: cycles of forward clearance after an avoidance turn.
- LEG_CYC, 400_000_000: cycles per search-pattern forward leg.
- SWEEP_CYC, 200_000_000: cycles per search-pattern turn.
- DROP_CYC, 50_000_000: cycles the magnet is released.
- DEB_CYC, 1000: cycles an input must be stable before it is accepted.
- MAX_WASHERS, 4: deliveries before the block halts.
- CNT_W, 32: width of the shared timer.
REQ-002 Ports (name, direction, width, meaning), one per line:
- CLK100MHZ, in, 1: the single clock.
- reset, in, 1: synchronous, active-high.
- ir_front / ir_left / ir_right, in, 1 each: obstacle flag, 1 = obstacle.
- metal_det, in, 1: washer under the pickup, 1 = present.
- color_valid, in, 1: one-cycle strobe qualifying color_code.
- color_code, in, 3: 000 red, 001 blue, 010 green, 011 yellow, 100 unknown.
- led_match, in, 1: the target LED for the carried colour is detected.
- direction, out, 3: 000 fwd, 001 back, 010 stop, 100 left, 101 right.
- speed, out, 2: 0 = off, 3 = full.
- magnet_on, out, 1: electromagnet enable.
- held_color, out, 3: latched colour of the carried washer.
- washer_count, out, $clog2(MAX_WASHERS+1): completed deliveries.
- state_dbg, out, 4: current state encoding.

Function
REQ-003 States: SEARCH_FWD, SEARCH_TURN, AVOID_TURN, AVOID_FWD, PICKUP, CARRY, DROP, DONE.
REQ-004 Each IR, metal_det and led_match input passes through its own debouncer; the filtered value changes only after the raw value has been stable for DEB_CYC consecutive cycles.
REQ-005 One timer is used, CNT_W bits wide; it clears to 0 on every state entry and saturates at all-ones.
REQ-006 Obstacle priority, checked in SEARCH_FWD, SEARCH_TURN, AVOID_FWD and CARRY; the block enters AVOID_TURN when the first match applies:
- front and left both set: turn right.
- front and right both set: turn left.
- front only: turn left.
- left and right set without front: no avoidance.
REQ-007 AVOID_TURN outputs the latched turn direction at speed 3 for TURN_CYC cycles, then goes to AVOID_FWD.
REQ-008 AVOID_FWD drives forward at speed 3 for FWD_CYC cycles, then returns to the latched return state (SEARCH_FWD or CARRY).
REQ-009 SEARCH_FWD drives forward at speed 3. After LEG_CYC cycles it goes to SEARCH_TURN, whose turn direction alternates left/right on each entry; the first turn after reset is left.
REQ-010 SEARCH_TURN lasts SWEEP_CYC cycles, then goes to SEARCH_FWD.
REQ-011 In SEARCH_FWD or SEARCH_TURN, a filtered metal_det wins over any obstacle in the same cycle and moves the block to PICKUP.
REQ-012 PICKUP drives stop at speed 0 with magnet_on = 1 and waits for color_valid:
- on the strobe, color_code is latched into held_color and the block goes to CARRY;
- if no strobe arrives within SWEEP_CYC cycles, held_color = 100 and the block goes to CARRY.
REQ-013 CARRY runs the SEARCH_FWD/SEARCH_TURN pattern with magnet_on held at 1; a filtered led_match moves it to DROP.
REQ-014 DROP drives stop at speed 0 with magnet_on = 0 for DROP_CYC cycles, then increments washer_count. It then goes to DONE if washer_count equals MAX_WASHERS, otherwise to SEARCH_FWD.
REQ-015 DONE drives stop at speed 0 with magnet_on = 0 and is left only by reset.
REQ-016 Outputs are registered: a state change appears on the outputs one cycle after the deciding input is sampled.
REQ-017 metal_det is ignored in CARRY, DROP and DONE; led_match is ignored outside CARRY.

Reset
REQ-018 While reset = 1, the block holds these values on every clock edge, overriding any in-progress manoeuvre:
- state SEARCH_FWD, direction 010, speed 0, magnet_on 0;
- held_color 100, washer_count 0, timer 0;
- debouncers cleared to 0, turn alternation set to left.
REQ-019 On the first cycle after reset deasserts, direction becomes 000 and speed becomes 3.

Structure
REQ-020 The direction codes, colour codes and state encodings belong in a shared package, nav_pkg, which movementMain also uses.
REQ-021 The debouncer is the one sub-module, input_debounce, parametrised by DEB_CYC and instantiated five times.

Verification
REQ-022 Benches run with all cycle parameters set to 8–20 for simulation speed, and cover these directed scenarios:
- Reset mid-AVOID_TURN: assert reset -> next cycle direction = 010, speed = 0, state_dbg = SEARCH_FWD.
- ir_front held for DEB_CYC+1 cycles in SEARCH_FWD -> direction = 100 for TURN_CYC cycles, then 000 for FWD_CYC cycles, then SEARCH_FWD.
- ir_front and ir_left both high -> direction = 101. ir_left only -> no state change.
- metal_det and ir_front raised together in SEARCH_FWD -> PICKUP with magnet_on = 1. color_valid with code 010 -> held_color = 010 and CARRY.
- PICKUP with no strobe for SWEEP_CYC cycles -> held_color = 100 and CARRY.
- Four full pickup/led_match/drop cycles -> washer_count steps 1 to 4, then DONE with speed = 0; further stimulus ignored.
